// File: rtl/spi_top.sv
// SPI mode-0 slave that sets and reads back per-LED 7-bit brightness and drives each LED with PWM.
// Optional debug outputs are compiled in when SPI_DEBUG_EN is defined.
`timescale 1ns/1ps
module spi_top #(
  parameter int NUM_LEDS         = 8,
  parameter int BRIGHTNESS_WIDTH = 7,
  parameter int FRAME_WIDTH      = 24,
  parameter int SYNC_STAGES      = 2
) (
  input  logic sysclk,
  input  logic rst,
  input  logic sclk,
  input  logic cs,
  input  logic mosi,
  output logic miso,
  output logic led1,
  output logic led2,
  output logic led3,
  output logic led4,
  output logic led5,
  output logic led6,
  output logic led7,
  output logic led8
`ifdef SPI_DEBUG_EN
  ,
  output logic                        debug_rx_dv,
  output logic [7:0]                  debug_cmd,
  output logic [7:0]                  debug_addr,
  output logic [7:0]                  debug_payload,
  output logic [BRIGHTNESS_WIDTH-1:0] debug_led0_brightness,
  output logic                        debug_led0_pwm
`endif
);

  localparam int FIELD_W = 8;
  localparam int BW      = BRIGHTNESS_WIDTH;
  localparam int CNT_W   = $clog2(FRAME_WIDTH + 1);
  localparam int AW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [CNT_W-1:0]   CNT_FULL     = CNT_W'(FRAME_WIDTH);
  localparam logic [CNT_W-1:0]   CNT_RESP     = CNT_W'(FRAME_WIDTH - FIELD_W);
  localparam logic [BW-1:0]      PWM_LAST     = BW'((1 << BW) - 2);
  localparam logic [FIELD_W-1:0] NUM_LEDS_B   = FIELD_W'(NUM_LEDS);
  localparam logic [FIELD_W-1:0] CMD_LED_SET  = 8'h01;
  localparam logic [FIELD_W-1:0] CMD_LED_READ = 8'h02;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   sclk_prev_q, cs_prev_q;
  logic                   sclk_s, cs_s, mosi_s;
  logic                   sclk_rise, cs_rise, cs_fall;

  logic [FRAME_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d, cnt_inc;
  logic [FIELD_W-1:0]     tx_q, tx_d;
  logic                   miso_q, miso_d;
  logic [BW-1:0]          pwm_q, pwm_d;
  logic [NUM_LEDS-1:0]    led_q, led_d;
  logic [BW-1:0]          bright_q [NUM_LEDS];
  logic [BW-1:0]          bright_d [NUM_LEDS];

  logic [FIELD_W-1:0]     hdr_cmd, hdr_addr;
  logic [FIELD_W-1:0]     f_cmd, f_addr;
  logic                   frame_commit;

  assign sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
  assign cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs};
  assign mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};

  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  assign shift_in = {shift_q[FRAME_WIDTH-2:0], mosi_s};
  assign cnt_inc  = bit_cnt_q + 1'b1;
  // After the 16th bit the low two bytes of the shifter hold cmd and addr.
  assign hdr_cmd  = shift_in[2*FIELD_W-1:FIELD_W];
  assign hdr_addr = shift_in[FIELD_W-1:0];

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    if (cs_fall) begin
      shift_d   = '0;
      bit_cnt_d = '0;
      tx_d      = '0;
    end else if (sclk_rise && (!cs_s || cs_rise) && (bit_cnt_q != CNT_FULL)) begin
      // A cs rise coincident with the last edge still shifts that bit in.
      shift_d   = shift_in;
      bit_cnt_d = cnt_inc;
      if (cnt_inc == CNT_RESP) begin
        if ((hdr_cmd == CMD_LED_READ) && (hdr_addr < NUM_LEDS_B)) begin
          tx_d = FIELD_W'(bright_q[hdr_addr[AW-1:0]]);
        end else begin
          tx_d = '0;
        end
      end else begin
        tx_d = {tx_q[FIELD_W-2:0], 1'b0};
      end
    end
    miso_d = (!cs_s && (bit_cnt_d >= CNT_RESP)) ? tx_d[FIELD_W-1] : 1'b0;
  end

  assign f_cmd        = shift_d[FRAME_WIDTH-1 -: FIELD_W];
  assign f_addr       = shift_d[FIELD_W +: FIELD_W];
  assign frame_commit = cs_rise && (bit_cnt_d == CNT_FULL);

  always_comb begin
    bright_d = bright_q;
    if (frame_commit && (f_cmd == CMD_LED_SET) && (f_addr < NUM_LEDS_B)) begin
      bright_d[f_addr[AW-1:0]] = shift_d[FIELD_W-1 -: BW];
    end
    pwm_d = (pwm_q == PWM_LAST) ? '0 : pwm_q + 1'b1;
    for (int i = 0; i < NUM_LEDS; i++) begin
      led_d[i] = (pwm_q < bright_q[i]);
    end
  end

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      tx_q        <= '0;
      miso_q      <= 1'b0;
      pwm_q       <= '0;
      led_q       <= '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
        bright_q[i] <= '0;
      end
    end else begin
      sclk_sync_q <= sclk_sync_d;
      cs_sync_q   <= cs_sync_d;
      mosi_sync_q <= mosi_sync_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      miso_q      <= miso_d;
      pwm_q       <= pwm_d;
      led_q       <= led_d;
      bright_q    <= bright_d;
    end
  end

  assign miso = miso_q;
  assign led1 = led_q[0];
  assign led2 = led_q[1];
  assign led3 = led_q[2];
  assign led4 = led_q[3];
  assign led5 = led_q[4];
  assign led6 = led_q[5];
  assign led7 = led_q[6];
  assign led8 = led_q[7];

`ifdef SPI_DEBUG_EN
  logic               dbg_rx_dv_q;
  logic [FIELD_W-1:0] dbg_cmd_q, dbg_addr_q, dbg_payload_q;

  always_ff @(posedge sysclk or posedge rst) begin
    if (rst) begin
      dbg_rx_dv_q   <= 1'b0;
      dbg_cmd_q     <= '0;
      dbg_addr_q    <= '0;
      dbg_payload_q <= '0;
    end else begin
      dbg_rx_dv_q <= frame_commit;
      if (frame_commit) begin
        dbg_cmd_q     <= f_cmd;
        dbg_addr_q    <= f_addr;
        dbg_payload_q <= shift_d[FIELD_W-1:0];
      end
    end
  end

  assign debug_rx_dv           = dbg_rx_dv_q;
  assign debug_cmd             = dbg_cmd_q;
  assign debug_addr            = dbg_addr_q;
  assign debug_payload         = dbg_payload_q;
  assign debug_led0_brightness = bright_q[0];
  assign debug_led0_pwm        = led_q[0];
`endif

endmodule

// File: tb/tb_spi_top.sv
// Self-checking bench for spi_top: directed vector table, randomized frames against a
// brightness-array reference model, coincident cs/sclk edge and mid-frame reset.
`timescale 1ns/1ps
module tb_spi_top;
  localparam int HALF = 5;

  logic sysclk = 1'b0;
  logic rst, sclk, cs, mosi, miso;
  logic led1, led2, led3, led4, led5, led6, led7, led8;
  logic [7:0] leds;

  always #4 sysclk = ~sysclk;

  spi_top dut (
    .sysclk(sysclk), .rst(rst), .sclk(sclk), .cs(cs), .mosi(mosi), .miso(miso),
    .led1(led1), .led2(led2), .led3(led3), .led4(led4),
    .led5(led5), .led6(led6), .led7(led7), .led8(led8)
  );

  assign leds = {led8, led7, led6, led5, led4, led3, led2, led1};

  int n_checks = 0;
  int n_fail   = 0;
  int model_b [8];
  int duty [8];

  typedef struct {
    logic [23:0] frame;
    int          nbits;
    int          win;
    int          idx;
    int          exp_duty;
    int          exp_rx;
  } vec_t;

  vec_t vecs [14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Master side of one transaction; bits past 24 carry random filler.
  task automatic spi_xfer(input logic [23:0] data, input int nbits, input bit cs_with_last,
                          output logic [7:0] rx);
    rx = 8'h00;
    cs = 1'b0;
    repeat (6) @(negedge sysclk);
    for (int i = 0; i < nbits; i++) begin
      if (i < 24) mosi = data[23-i];
      else        mosi = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge sysclk);
      if (i >= 16 && i < 24) rx = {rx[6:0], miso};
      sclk = 1'b1;
      if (cs_with_last && i == nbits - 1) cs = 1'b1;
      repeat (HALF) @(negedge sysclk);
      sclk = 1'b0;
    end
    repeat (HALF) @(negedge sysclk);
    cs = 1'b1;
    repeat (8) @(negedge sysclk);
  endtask

  // Reference: a read returns the pre-frame value; a complete SET writes payload>>1.
  task automatic model_frame(input logic [23:0] data, input int nbits, output int exp_rx);
    int cmd, addr;
    cmd    = int'(data[23:16]);
    addr   = int'(data[15:8]);
    exp_rx = 0;
    if (nbits >= 16 && cmd == 2 && addr < 8) exp_rx = model_b[addr];
    if (nbits >= 24 && cmd == 1 && addr < 8) model_b[addr] = int'(data[7:0]) / 2;
  endtask

  task automatic measure(input int win);
    for (int i = 0; i < 8; i++) duty[i] = 0;
    repeat (win) begin
      @(negedge sysclk);
      for (int i = 0; i < 8; i++) if (leds[i]) duty[i]++;
    end
  endtask

  task automatic check_model_leds(input string tag, input int win);
    for (int i = 0; i < 8; i++)
      check($sformatf("%s_led%0d_duty", tag, i + 1), duty[i], model_b[i] * win / 127);
  endtask

  initial begin
    logic [7:0]  rx;
    logic [23:0] frame;
    logic [7:0]  cmd, addr, payload;
    int          exp_rx, nbits, r;

    rst = 1'b1; sclk = 1'b0; cs = 1'b1; mosi = 1'b0;
    for (int i = 0; i < 8; i++) model_b[i] = 0;
    repeat (5) @(negedge sysclk);
    check("reset_miso", int'(miso), 0);
    check("reset_leds", int'(leds), 0);
    rst = 1'b0;
    repeat (5) @(negedge sysclk);

    vecs[0]  = '{24'h00FF00, 24, 254, 0, 0,   0};
    vecs[1]  = '{24'h010014, 24, 127, 0, 10,  0};
    vecs[2]  = '{24'h010714, 24, 127, 7, 10,  0};
    vecs[3]  = '{24'h01FFFF, 24, 127, 7, 10,  0};
    vecs[4]  = '{24'h010316, 24, 127, 3, 11,  0};
    vecs[5]  = '{24'h010300, 24, 127, 3, 0,   0};
    vecs[6]  = '{24'h02070C, 24, 127, 7, 10,  8'h0A};
    vecs[7]  = '{24'h010055, 12, 127, 0, 10,  0};
    vecs[8]  = '{24'h0100FF, 24, 127, 0, 127, 0};
    vecs[9]  = '{24'h020000, 24, 127, 0, 127, 8'h7F};
    vecs[10] = '{24'h021000, 24, 127, 0, 127, 0};
    vecs[11] = '{24'h050233, 24, 127, 2, 0,   0};
    vecs[12] = '{24'h010601, 24, 127, 5, 0,   0};
    vecs[13] = '{24'h020300, 24, 127, 3, 0,   0};

    for (int v = 0; v < 14; v++) begin
      model_frame(vecs[v].frame, vecs[v].nbits, exp_rx);
      spi_xfer(vecs[v].frame, vecs[v].nbits, 1'b0, rx);
      $display("vec %0d: frame=%06h bits=%0d rx=%02h", v, vecs[v].frame, vecs[v].nbits, rx);
      if (vecs[v].nbits >= 24) check($sformatf("vec%0d_rx", v), int'(rx), vecs[v].exp_rx);
      check($sformatf("vec%0d_idle_miso", v), int'(miso), 0);
      measure(vecs[v].win);
      check($sformatf("vec%0d_led%0d_duty", v, vecs[v].idx + 1), duty[vecs[v].idx], vecs[v].exp_duty);
      check_model_leds($sformatf("vec%0d", v), vecs[v].win);
    end

    for (int t = 0; t < 40; t++) begin
      r = int'($urandom_range(0, 9));
      if (r < 4)      cmd = 8'h01;
      else if (r < 7) cmd = 8'h02;
      else if (r < 8) cmd = 8'h00;
      else            cmd = 8'($urandom);
      r = int'($urandom_range(0, 11));
      if (r < 8)       addr = 8'($urandom_range(0, 7));
      else if (r == 8) addr = 8'hFF;
      else if (r == 9) addr = 8'h10;
      else             addr = 8'($urandom);
      payload = 8'($urandom);
      nbits   = ($urandom_range(0, 4) == 0) ? int'($urandom_range(10, 30)) : 24;
      frame   = {cmd, addr, payload};
      model_frame(frame, nbits, exp_rx);
      spi_xfer(frame, nbits, 1'b0, rx);
      $display("rand %0d: frame=%06h bits=%0d rx=%02h", t, frame, nbits, rx);
      if (nbits >= 24) check($sformatf("rand%0d_rx", t), int'(rx), exp_rx);
      measure(127);
      check_model_leds($sformatf("rand%0d", t), 127);
    end

    // cs released on the same sysclk as the 24th sclk rise still commits.
    frame = 24'h010540;
    model_frame(frame, 24, exp_rx);
    spi_xfer(frame, 24, 1'b1, rx);
    $display("coincident cs/sclk: frame=%06h", frame);
    measure(127);
    check("coincident_led6_duty", duty[5], 32);
    check_model_leds("coincident", 127);

    // Reset in the middle of a SET frame.
    cs = 1'b0;
    repeat (6) @(negedge sysclk);
    frame = 24'h0102AA;
    for (int i = 0; i < 10; i++) begin
      mosi = frame[23-i];
      repeat (HALF) @(negedge sysclk);
      sclk = 1'b1;
      repeat (HALF) @(negedge sysclk);
      sclk = 1'b0;
    end
    rst = 1'b1;
    repeat (3) @(negedge sysclk);
    check("midrst_leds", int'(leds), 0);
    check("midrst_miso", int'(miso), 0);
    cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
    repeat (2) @(negedge sysclk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) model_b[i] = 0;
    $display("mid-frame reset applied after 10 bits");
    repeat (5) @(negedge sysclk);
    check("post_rst_miso", int'(miso), 0);
    measure(127);
    check_model_leds("post_rst", 127);

    frame = 24'h010228;
    model_frame(frame, 24, exp_rx);
    spi_xfer(frame, 24, 1'b0, rx);
    $display("post-reset set: frame=%06h", frame);
    measure(127);
    check("post_rst_led3_duty", duty[2], 20);
    check_model_leds("post_rst_set", 127);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
